// File: rtl/swap_seq.sv
// Sequencer that issues a counted series of one-cycle swap requests to a swap unit,
// waits for each to complete, and flags a timeout if the unit never acknowledges.
module swap_seq #(
  parameter int CNT_W = 4,
  parameter int TMO   = 7
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  input  logic             done_in,
  output logic             w,
  output logic             busy,
  output logic             finished,
  output logic             err,
  output logic [CNT_W-1:0] completed
);

  // Counter only has to reach TMO-1, the value at which the last permitted ACK cycle ends.
  localparam int TW = (TMO < 2) ? 1 : $clog2(TMO);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    WAIT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             w_nx;
  logic             fin_nx;
  logic             err_nx;
  logic [CNT_W-1:0] cmp_nx;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] n_nx;
  logic [TW-1:0]    tmo_cnt;
  logic [TW-1:0]    tmo_nx;

  always_ff @(posedge ck) begin
    if (!rst) begin
      state     <= IDLE;
      w         <= 1'b0;
      finished  <= 1'b0;
      err       <= 1'b0;
      completed <= '0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nx;
      w         <= w_nx;
      finished  <= fin_nx;
      err       <= err_nx;
      completed <= cmp_nx;
      tmo_cnt   <= tmo_nx;
    end
  end

  // The latched request length only matters once a sequence is running.
  always_ff @(posedge ck) begin
    n_lat <= n_nx;
  end

  always_comb begin
    state_nx = state;
    fin_nx   = 1'b0;
    err_nx   = err;
    cmp_nx   = completed;
    n_nx     = n_lat;
    tmo_nx   = tmo_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          err_nx = 1'b0;
          cmp_nx = '0;
          if (n != '0) begin
            n_nx     = n;
            state_nx = REQ;
          end else begin
            fin_nx = 1'b1;
          end
        end
      end

      REQ: begin
        state_nx = ACK;
        tmo_nx   = '0;
      end

      ACK: begin
        if (!done_in) begin
          state_nx = WAIT;
        end else if (tmo_cnt == TW'(TMO - 1)) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          tmo_nx = tmo_cnt + TW'(1);
        end
      end

      WAIT: begin
        if (done_in) begin
          cmp_nx = completed + CNT_W'(1);
          if (cmp_nx == n_lat) begin
            state_nx = IDLE;
            fin_nx   = 1'b1;
          end else begin
            state_nx = REQ;
          end
        end
      end

      default: state_nx = IDLE;
    endcase

    // w is registered from the next state, so it is high exactly while in REQ.
    w_nx = (state_nx == REQ);
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_swap_seq.sv
// Self-checking bench for swap_seq: a procedural sequence model checked every cycle,
// directed scenarios with literal timing expectations, then randomized traffic.
module tb_swap_seq;

  localparam int CNT_W = 4;
  localparam int TMO   = 7;

  logic             ck;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] n;
  logic             done_in;
  logic             w;
  logic             busy;
  logic             finished;
  logic             err;
  logic [CNT_W-1:0] completed;

  swap_seq #(.CNT_W(CNT_W), .TMO(TMO)) dut (
    .ck       (ck),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .done_in  (done_in),
    .w        (w),
    .busy     (busy),
    .finished (finished),
    .err      (err),
    .completed(completed)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 0;

  // swap unit behaviour controls
  bit stuck = 0;
  bit rmode = 0;

  // expected outputs from the model
  bit m_w, m_busy, m_fin, m_err;
  int m_cmp;

  // event logs for directed checks
  int w_q[$];
  int fin_q[$];
  bit busy_seen;
  int err_at;
  bit err_prev;
  int t0;

  initial begin
    ck = 0;
    forever #5 ck = ~ck;
  end

  always @(posedge ck) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Swap unit: after seeing w, optionally stays high for dly cycles, then drops
  // done for a stretch and raises it again.
  initial begin : swap_unit
    int dly, left, lowlen;
    dly = 0; left = 0; lowlen = 3;
    done_in = 1;
    forever begin
      @(negedge ck);
      if (stuck) begin
        done_in = 1; dly = 0; left = 0;
      end else if (w) begin
        if (rmode) begin
          if (int'($urandom_range(0, 9)) == 0) dly = 8;
          else dly = int'($urandom_range(0, 2));
          lowlen = int'($urandom_range(1, 4));
        end else begin
          dly = 0; lowlen = 3;
        end
        left = lowlen + 1;
        if (dly == 0) done_in = 0;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) done_in = 0;
      end else if (left > 0) begin
        left--;
        if (left == 0) done_in = 1;
      end
    end
  end

  // Behavioural model: a sequence is walked procedurally, swap by swap.
  task automatic m_reset();
    m_w = 0; m_busy = 0; m_fin = 0; m_err = 0; m_cmp = 0;
  endtask

  task automatic run_seq(input int total);
    int acks;
    bit fell;
    m_busy = 1;
    for (int sw = 0; sw < total; sw++) begin
      m_w = 1;
      @(posedge ck);
      if (!rst) begin m_reset(); return; end
      m_w = 0;
      acks = 0;
      fell = 0;
      while (!fell) begin
        @(posedge ck);
        if (!rst) begin m_reset(); return; end
        if (!done_in) fell = 1;
        else begin
          acks++;
          if (acks == TMO) begin m_err = 1; m_busy = 0; return; end
        end
      end
      do begin
        @(posedge ck);
        if (!rst) begin m_reset(); return; end
      end while (!done_in);
      m_cmp = sw + 1;
    end
    m_busy = 0;
    m_fin  = 1;
  endtask

  initial begin : model
    m_reset();
    forever begin
      @(posedge ck);
      m_fin = 0;
      if (!rst) m_reset();
      else if (start) begin
        m_err = 0;
        m_cmp = 0;
        if (n == '0) m_fin = 1;
        else run_seq(int'(n));
      end
    end
  end

  // Per-cycle compare against the model, plus event logging.
  initial begin : compare
    forever begin
      @(negedge ck);
      if (chk_en) begin
        chk("w", int'(w), int'(m_w));
        chk("busy", int'(busy), int'(m_busy));
        chk("finished", int'(finished), int'(m_fin));
        chk("err", int'(err), int'(m_err));
        chk("completed", int'(completed), m_cmp);
      end
      if (w) w_q.push_back(cyc);
      if (finished) fin_q.push_back(cyc);
      if (busy) busy_seen = 1;
      if (err && !err_prev) err_at = cyc;
      err_prev = err;
    end
  end

  task automatic go(input int nv);
    @(negedge ck);
    w_q.delete();
    fin_q.delete();
    busy_seen = 0;
    err_at = -1;
    t0 = cyc;
    start = 1;
    n = CNT_W'(nv);
    @(negedge ck);
    start = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge ck);
    chk(name, int'(busy), 0);
    repeat (3) @(negedge ck);
  endtask

  initial begin : main
    rst = 0; start = 0; n = '0;
    repeat (3) @(negedge ck);
    chk_en = 1;
    chk("rst_w", int'(w), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_finished", int'(finished), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_completed", int'(completed), 0);
    rst = 1;
    repeat (2) @(negedge ck);

    // two swaps with the nominal swap unit
    go(2);
    wait_idle("t1_idle", 60);
    chk("t1_wcount", w_q.size(), 2);
    chk("t1_w0", qat(w_q, 0), t0 + 1);
    chk("t1_w1", qat(w_q, 1), t0 + 6);
    chk("t1_fincount", fin_q.size(), 1);
    chk("t1_fin", qat(fin_q, 0), t0 + 11);
    chk("t1_completed", int'(completed), 2);

    // zero-length request
    go(0);
    wait_idle("t2_idle", 10);
    chk("t2_wcount", w_q.size(), 0);
    chk("t2_fin", qat(fin_q, 0), t0 + 1);
    chk("t2_fincount", fin_q.size(), 1);
    chk("t2_busy_seen", int'(busy_seen), 0);
    chk("t2_completed", int'(completed), 0);

    // swap unit never acknowledges
    stuck = 1;
    go(3);
    wait_idle("t3_idle", 60);
    chk("t3_wcount", w_q.size(), 1);
    chk("t3_err", int'(err), 1);
    chk("t3_err_at", err_at, t0 + 9);
    chk("t3_fincount", fin_q.size(), 0);
    chk("t3_completed", int'(completed), 0);
    stuck = 0;
    repeat (3) @(negedge ck);

    // reset during WAIT of the second swap
    go(4);
    repeat (7) @(negedge ck);
    rst = 0;
    @(negedge ck);
    chk("t4_w", int'(w), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_finished", int'(finished), 0);
    chk("t4_err", int'(err), 0);
    chk("t4_completed", int'(completed), 0);
    rst = 1;
    repeat (25) @(negedge ck);
    chk("t4_wcount", w_q.size(), 2);
    chk("t4_fincount", fin_q.size(), 0);

    // start re-asserted while busy is ignored
    go(1);
    @(negedge ck);
    start = 1; n = CNT_W'(5);
    repeat (2) @(negedge ck);
    start = 0;
    wait_idle("t5_idle", 40);
    chk("t5_wcount", w_q.size(), 1);
    chk("t5_fincount", fin_q.size(), 1);
    chk("t5_completed", int'(completed), 1);

    // maximum length
    go(15);
    wait_idle("t6_idle", 200);
    chk("t6_wcount", w_q.size(), 15);
    chk("t6_w14", qat(w_q, 14), t0 + 1 + 14 * 5);
    chk("t6_fincount", fin_q.size(), 1);
    chk("t6_fin", qat(fin_q, 0), t0 + 76);
    chk("t6_completed", int'(completed), 15);

    // randomized traffic against the model
    rmode = 1;
    for (int it = 0; it < 1500; it++) begin
      @(negedge ck);
      start = (int'($urandom_range(0, 3)) == 0);
      if (int'($urandom_range(0, 4)) == 0) n = CNT_W'($urandom_range(0, 15));
      else n = CNT_W'($urandom_range(0, 3));
      rst = (int'($urandom_range(0, 80)) != 0);
    end
    start = 0;
    rst = 1;
    repeat (5) @(negedge ck);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
